// File: rtl/lcd_pkg.sv
// lcd_pkg: constants and types shared by the LCD character streamer.
//   LCD_CMD_LINE0 / LCD_CMD_LINE1 : HD44780 "set DDRAM address" commands for line 0 / line 1
//   CHAR_SPACE                    : fill value of a blank frame
//   CHAR_LF                       : line-feed byte, moves the write pointer instead of being stored
//   lcd_state_t                   : streamer FSM states
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_LINE0 = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE1 = 8'hC0;
    localparam logic [7:0] CHAR_SPACE    = 8'h20;
    localparam logic [7:0] CHAR_LF       = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD0  = 3'd1,
        S_DATA0 = 3'd2,
        S_CMD1  = 3'd3,
        S_DATA1 = 3'd4
    } lcd_state_t;

endpackage

// File: rtl/lcd_char_buf.sv
// lcd_char_buf: frame buffer, DEPTH x 8 flops.
//   clk, rst  : clock, synchronous active-high reset (fills every byte with a space)
//   i_we      : write enable
//   i_waddr   : write address
//   i_wdata   : write byte
//   i_raddr   : read address (combinational read)
//   o_rdata   : byte at i_raddr; reflects the contents before any write on this edge
module lcd_char_buf
    import lcd_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [DEPTH-1:0][7:0] r_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= CHAR_SPACE;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lcd_char_streamer.sv
// lcd_char_streamer: accepts ASCII bytes into a 2-line frame buffer and streams the
// whole frame (line-0 address command, line 0, line-1 address command, line 1) to an
// LCD bus driver over a valid/ready byte interface whenever the buffer changes or a
// refresh is requested.
//   clk, rst          : clock, synchronous active-high reset (blank frame is streamed afterwards)
//   DATA_IN, trig     : one buffer write per cycle with trig=1; 0x0A jumps to the other line
//   refresh           : request a full redraw
//   out_valid/ready   : downstream handshake; out_rs=0 command, 1 character
//   out_data          : command or character byte
//   busy              : a frame is in flight
module lcd_char_streamer
    import lcd_pkg::*;
#(
    parameter int N_COLS = 16,
    parameter int N_ROWS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] DATA_IN,
    input  logic       trig,
    input  logic       refresh,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_rs,
    output logic [7:0] out_data,
    output logic       busy
);

    localparam int DEPTH = N_COLS * N_ROWS;
    localparam int AW    = $clog2(DEPTH);

    lcd_state_t    r_state, w_state_n;
    logic [AW-1:0] r_rp, w_rp_n;
    logic [AW-1:0] r_wp;
    logic          r_dirty;
    logic          r_valid, w_valid_n;
    logic          r_rs, w_rs_n;
    logic [7:0]    r_data, w_data_n;
    logic          w_clr_dirty;
    logic          w_xfer;
    logic          w_we;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_rd_data;

    assign w_xfer = r_valid & out_ready;
    assign w_we   = trig & (DATA_IN != CHAR_LF);

    lcd_char_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_wp),
        .i_wdata (DATA_IN),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // In the data states the byte being loaded next is rp+1; after a command it is rp.
    // Kept apart from the FSM block so the read path has no apparent loop through it.
    always_comb begin
        w_rd_addr = r_rp;
        if (r_state == S_DATA0 || r_state == S_DATA1) w_rd_addr = r_rp + AW'(1);
    end

    // Write pointer: LF jumps to the start of the other line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
        end else if (trig) begin
            if (DATA_IN == CHAR_LF)
                r_wp <= (r_wp < AW'(N_COLS)) ? AW'(N_COLS) : '0;
            else
                r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + AW'(1);
        end
    end

    // Dirty: any write, or a refresh that arrives mid-frame, queues another frame.
    // A refresh in IDLE starts the frame directly. Writes on the clearing edge win.
    always_ff @(posedge clk) begin
        if (rst)
            r_dirty <= 1'b1;
        else
            r_dirty <= (r_dirty & ~w_clr_dirty) | trig | (refresh & (r_state != S_IDLE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rp    <= '0;
            r_valid <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_n;
            r_rp    <= w_rp_n;
            r_valid <= w_valid_n;
            r_rs    <= w_rs_n;
            r_data  <= w_data_n;
        end
    end

    // Output register is reloaded only on a transfer (or frame start), so it holds
    // through stalls and ignores later buffer writes.
    always_comb begin
        w_state_n   = r_state;
        w_rp_n      = r_rp;
        w_valid_n   = r_valid;
        w_rs_n      = r_rs;
        w_data_n    = r_data;
        w_clr_dirty = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_dirty | refresh) begin
                    w_state_n   = S_CMD0;
                    w_clr_dirty = 1'b1;
                    w_rp_n      = '0;
                    w_valid_n   = 1'b1;
                    w_rs_n      = 1'b0;
                    w_data_n    = LCD_CMD_LINE0;
                end
            end
            S_CMD0: begin
                if (w_xfer) begin
                    w_state_n = S_DATA0;
                    w_rs_n    = 1'b1;
                    w_data_n  = w_rd_data;
                end
            end
            S_DATA0: begin
                if (w_xfer) begin
                    w_rp_n = r_rp + AW'(1);
                    if (r_rp == AW'(N_COLS - 1)) begin
                        w_state_n = S_CMD1;
                        w_rs_n    = 1'b0;
                        w_data_n  = LCD_CMD_LINE1;
                    end else begin
                        w_data_n  = w_rd_data;
                    end
                end
            end
            S_CMD1: begin
                if (w_xfer) begin
                    w_state_n = S_DATA1;
                    w_rs_n    = 1'b1;
                    w_data_n  = w_rd_data;
                end
            end
            S_DATA1: begin
                if (w_xfer) begin
                    if (r_rp == AW'(DEPTH - 1)) begin
                        w_state_n = S_IDLE;
                        w_rp_n    = '0;
                        w_valid_n = 1'b0;
                    end else begin
                        w_rp_n    = r_rp + AW'(1);
                        w_data_n  = w_rd_data;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_valid_n = 1'b0;
            end
        endcase
    end

    assign out_valid = r_valid;
    assign out_rs    = r_rs;
    assign out_data  = r_data;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_lcd_char_streamer.sv
// Self-checking bench for lcd_char_streamer. A byte-level model of the frame buffer
// and write pointer produces the expected frame, which is queued when the stimulus
// that causes it is driven; a monitor pops one entry per transfer.
module tb_lcd_char_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] DATA_IN = 8'h00;
    logic       trig = 1'b0;
    logic       refresh = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_rs;
    logic [7:0] out_data;
    logic       busy;

    lcd_char_streamer #(.N_COLS(16), .N_ROWS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .DATA_IN   (DATA_IN),
        .trig      (trig),
        .refresh   (refresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rs    (out_rs),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         xfer_cnt = 0;
    logic [8:0] sb[$];
    logic [7:0] mdl[32];
    int         mwp;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        mwp = 0;
    endtask

    task automatic push_frame();
        sb.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) sb.push_back({1'b1, mdl[i]});
        sb.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) sb.push_back({1'b1, mdl[i]});
    endtask

    // Called at posedge+#1; the write lands on the next edge.
    task automatic wr(input logic [7:0] b);
        DATA_IN = b;
        trig    = 1'b1;
        if (b == 8'h0A) begin
            mwp = (mwp < 16) ? 16 : 0;
        end else begin
            mdl[mwp] = b;
            mwp = (mwp + 1) % 32;
        end
        @(posedge clk); #1;
        trig = 1'b0;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(posedge clk); #1;
        refresh = 1'b0;
    endtask

    // Sampled on the falling edge, away from the DUT's active edge.
    task automatic run_monitor();
        int         pos = 0;
        logic       gap = 1'b0;
        logic       stall = 1'b0;
        logic [8:0] held = '0;
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                pos = 0; gap = 1'b0; stall = 1'b0;
            end else begin
                if (gap) begin
                    n_cmp++;
                    if (out_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL idle_gap: out_valid=%b required 0 after frame end", out_valid);
                    end
                    gap = 1'b0;
                end
                if (stall) begin
                    n_cmp++;
                    if (out_valid !== 1'b1 || {out_rs, out_data} !== held) begin
                        n_err++;
                        $display("FAIL stall_hold: valid=%b rs/data=%h required valid=1 rs/data=%h",
                                 out_valid, {out_rs, out_data}, held);
                    end
                end
                stall = (out_valid === 1'b1) && (out_ready === 1'b0);
                held  = {out_rs, out_data};
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    xfer_cnt++;
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_xfer: rs/data=%h with empty scoreboard", {out_rs, out_data});
                    end else begin
                        exp = sb.pop_front();
                        if ({out_rs, out_data} !== exp) begin
                            n_err++;
                            $display("FAIL xfer_byte: pos=%0d got rs/data=%h required %h", pos, {out_rs, out_data}, exp);
                        end
                    end
                    pos++;
                    if (pos == 34) begin
                        pos = 0;
                        gap = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && busy === 1'b0) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_timeout: %0d bytes still expected, busy=%b required drained", name, sb.size(), busy);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: busy=%b out_valid=%b required 0/0", name, busy, out_valid);
        end
    endtask

    task automatic check_stalled_cmd0(input string name);
        n_cmp++;
        if (out_valid !== 1'b1 || out_rs !== 1'b0 || out_data !== 8'h80) begin
            n_err++;
            $display("FAIL %s_start: valid=%b rs=%b data=%h required 1/0/80", name, out_valid, out_rs, out_data);
        end
    endtask

    task automatic wait_xfers(input int target, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk); #1;
            if (xfer_cnt >= target) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_reach: xfer_cnt=%0d required >= %0d", name, xfer_cnt, target);
        end
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_rs !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b rs=%b data=%h busy=%b required 0/0/00/0",
                     out_valid, out_rs, out_data, busy);
        end
        model_reset();
        push_frame();
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h80 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_cmd: valid=%b data=%h busy=%b required 1/80/1", out_valid, out_data, busy);
        end
        wait_idle("reset_frame");
    endtask

    // Downstream held off so both lines are complete before the first character is loaded;
    // the writes after the first re-dirty the buffer, so the frame is sent twice.
    task automatic test_hi_lf_ok();
        out_ready = 1'b0;
        wr("H"); wr("I"); wr(8'h0A); wr("O"); wr("K");
        push_frame();
        push_frame();
        check_stalled_cmd0("hi_ok");
        out_ready = 1'b1;
        wait_idle("hi_ok");
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        wr(8'h0A);                      // wp 18 -> 0
        for (int c = 8'h41; c <= 8'h61; c++) wr(8'(c));
        push_frame();
        push_frame();
        n_cmp++;
        if (mdl[0] !== 8'h61 || mdl[1] !== 8'h42 || mdl[31] !== 8'h60) begin
            n_err++;
            $display("FAIL wrap_model: [0]=%h [1]=%h [31]=%h required 61/42/60", mdl[0], mdl[1], mdl[31]);
        end
        check_stalled_cmd0("wrap");
        out_ready = 1'b1;
        wait_idle("wrap");
    endtask

    task automatic test_stall();
        bit done = 1'b0;
        pulse_refresh();
        push_frame();
        for (int i = 0; i < 3000 && !done; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (sb.size() == 0 && busy === 1'b0) done = 1'b1;
        end
        out_ready = 1'b1;
        wait_idle("stall");
    endtask

    task automatic test_write_mid_frame();
        int base;
        out_ready = 1'b0;
        while (mwp != 0) wr(8'h0A);
        wr("0"); wr("1"); wr("2"); wr("3"); wr("4");
        push_frame();
        push_frame();
        out_ready = 1'b1;
        wait_idle("mid_prep");
        base = xfer_cnt;
        pulse_refresh();
        push_frame();                   // still holds '4' at index 4, '4'..: index 5 is 0x46 from wrap
        wait_xfers(base + 12, "mid_write");
        wr("Z");                        // wp=5, already streamed in this frame
        push_frame();
        wait_idle("mid_write");
    endtask

    task automatic test_reset_mid_frame();
        int base;
        out_ready = 1'b1;
        base = xfer_cnt;
        pulse_refresh();
        push_frame();
        wait_xfers(base + 22, "rst_mid");
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_drop: out_valid=%b busy=%b required 0/0", out_valid, busy);
        end
        sb.delete();
        model_reset();
        push_frame();
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle("rst_mid");
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_hi_lf_ok();
        test_wrap();
        test_stall();
        test_write_mid_frame();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
